// File: rtl/bitwise_unit_arbiter_if.sv
// bitwise_unit_arbiter_if
//   Handshake/bus bundle between NREQ requesters and the shared bitwise unit.
//   Requester side : req, op_bus, x_bus, y_bus, out_ready   (driven by master)
//   Unit side      : gnt, out, out_id, out_valid, busy      (driven by slave)
//   Optional       : gnt_cnt, present only when BITWISE_ARB_GNTCNT_EN is defined.
interface bitwise_unit_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op_bus;
  logic [WIDTH*NREQ-1:0] x_bus;
  logic [WIDTH*NREQ-1:0] y_bus;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      out;
  logic [IDW-1:0]        out_id;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
`ifdef BITWISE_ARB_GNTCNT_EN
  logic [15:0]           gnt_cnt;

  modport master (output req, op_bus, x_bus, y_bus, out_ready,
                  input  gnt, out, out_id, out_valid, busy, gnt_cnt);
  modport slave  (input  req, op_bus, x_bus, y_bus, out_ready,
                  output gnt, out, out_id, out_valid, busy, gnt_cnt);
`else
  modport master (output req, op_bus, x_bus, y_bus, out_ready,
                  input  gnt, out, out_id, out_valid, busy);
  modport slave  (input  req, op_bus, x_bus, y_bus, out_ready,
                  output gnt, out, out_id, out_valid, busy);
`endif
endinterface

// File: rtl/bitwise_unit_arbiter.sv
// bitwise_unit_arbiter
//   One shared 16-bit OR/AND/XOR/NOR unit serving NREQ requesters with
//   round-robin arbitration. IDLE -> EXEC -> HOLD per transaction.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   io_bus  : bitwise_unit_arbiter_if.slave (req/op/x/y in, gnt/out/out_id/
//             out_valid/busy out, out_ready in)
// Optional feature macro: BITWISE_ARB_GNTCNT_EN adds a saturating 16-bit
//   count of grant cycles on io_bus.gnt_cnt.
module bitwise_unit_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  bitwise_unit_arbiter_if.slave  io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_x, r_y;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_out;
  logic [IDW-1:0]   r_out_id;
  logic             r_out_valid;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_win_nxt;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] a, input int k);
    logic [IDW:0] s;
    s = {1'b0, a} + (IDW+1)'(k);
    if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
    return s[IDW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] bit_op(input logic [1:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (op)
      2'b00:   return x | y;
      2'b01:   return x & y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Round-robin pick: first set req bit at or after r_ptr, wrapping.
  always_comb begin
    logic [IDW-1:0] w_idx;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = wrap_inc(r_ptr, k);
      if (!w_found && io_bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_win_nxt = wrap_inc(w_win, 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_op        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_gnt       <= '0;
      r_out       <= '0;
      r_out_id    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gnt <= '0;
          if (w_found) begin
            // Only the winner's lane is read, so unselected lanes can't leak X.
            r_op     <= io_bus.op_bus[2*w_win +: 2];
            r_x      <= io_bus.x_bus[WIDTH*w_win +: WIDTH];
            r_y      <= io_bus.y_bus[WIDTH*w_win +: WIDTH];
            r_gnt    <= NREQ'(1) << w_win;
            r_out_id <= w_win;
            r_ptr    <= w_win_nxt;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_gnt       <= '0;
          r_out       <= bit_op(r_op, r_x, r_y);
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          // out is left as-is after the handshake; it changes only in EXEC.
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.gnt       = r_gnt;
  assign io_bus.out       = r_out;
  assign io_bus.out_id    = r_out_id;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.busy      = (r_state != S_IDLE);

`ifdef BITWISE_ARB_GNTCNT_EN
  logic [15:0] r_gnt_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                 r_gnt_cnt <= '0;
    else if (|r_gnt && r_gnt_cnt != 16'hFFFF) r_gnt_cnt <= r_gnt_cnt + 16'd1;
  end

  assign io_bus.gnt_cnt = r_gnt_cnt;
`endif

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// tb_bitwise_unit_arbiter
//   Directed-vector bench for bitwise_unit_arbiter. Inputs change 1 time unit
//   after a rising edge; outputs are sampled at that same point.
module tb_bitwise_unit_arbiter;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  bitwise_unit_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) io_bus ();

  bitwise_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (io_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int id, input logic [1:0] op,
                          input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    io_bus.op_bus[2*id +: 2]       = op;
    io_bus.x_bus[WIDTH*id +: WIDTH] = x;
    io_bus.y_bus[WIDTH*id +: WIDTH] = y;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction for requester id with out_ready=1; req dropped in gnt cycle.
  task automatic txn(input string tag, input int id, input logic [1:0] op,
                     input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                     input logic [WIDTH-1:0] exp_out);
    set_lane(id, op, x, y);
    io_bus.req[id] = 1'b1;
    tick();
    chk({tag, "_gnt"}, 32'(io_bus.gnt), 32'(4'b0001 << id));
    io_bus.req[id] = 1'b0;
    tick();
    chk({tag, "_out"}, 32'(io_bus.out), 32'(exp_out));
    chk({tag, "_id"},  32'(io_bus.out_id), 32'(id));
    tick();
  endtask

  logic [WIDTH-1:0] rr_x [5];
  int               rr_id [5];
  logic [WIDTH-1:0] held;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    io_bus.req       = '0;
    io_bus.op_bus    = '0;
    io_bus.x_bus     = '0;
    io_bus.y_bus     = '0;
    io_bus.out_ready = 1'b1;
    #1;
    do_reset();

    // reset state
    chk("rst_gnt",   32'(io_bus.gnt), 0);
    chk("rst_out",   32'(io_bus.out), 0);
    chk("rst_id",    32'(io_bus.out_id), 0);
    chk("rst_valid", 32'(io_bus.out_valid), 0);
    chk("rst_busy",  32'(io_bus.busy), 0);

    // single request with full latency profile
    set_lane(0, 2'b00, 16'h00F0, 16'h0F00);
    io_bus.req = 4'b0001;
    chk("s_idle_gnt", 32'(io_bus.gnt), 0);
    tick();
    chk("s_gnt",   32'(io_bus.gnt), 32'h1);
    chk("s_busy",  32'(io_bus.busy), 1);
    chk("s_v0",    32'(io_bus.out_valid), 0);
    io_bus.req = '0;
    tick();
    chk("s_gnt0",  32'(io_bus.gnt), 0);
    chk("s_valid", 32'(io_bus.out_valid), 1);
    chk("s_out",   32'(io_bus.out), 32'h0FF0);
    chk("s_id",    32'(io_bus.out_id), 0);
    tick();
    chk("s_vdrop", 32'(io_bus.out_valid), 0);
    chk("s_hold",  32'(io_bus.out), 32'h0FF0);
    chk("s_idle",  32'(io_bus.busy), 0);

    // round robin, all four requesting continuously
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 2'b00, 16'h1111 * 16'(i + 1), 16'h0000);
    rr_id = '{0, 1, 2, 3, 0};
    rr_x  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
    io_bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("rr_gnt", 32'(io_bus.gnt), 32'(4'b0001 << rr_id[t]));
      tick();
      chk("rr_id",  32'(io_bus.out_id), 32'(rr_id[t]));
      chk("rr_out", 32'(io_bus.out), 32'(rr_x[t]));
      tick();
    end
    io_bus.req = '0;
    tick();
    tick();
    tick();

    // opcode coverage on requester 2
    do_reset();
    txn("op_or",  2, 2'b00, 16'hAAAA, 16'hFFFF, 16'hFFFF);
    txn("op_and", 2, 2'b01, 16'hAAAA, 16'hFFFF, 16'hAAAA);
    txn("op_xor", 2, 2'b10, 16'hAAAA, 16'hFFFF, 16'h5555);
    txn("op_nor", 2, 2'b11, 16'hAAAA, 16'hFFFF, 16'h0000);
    txn("op_nor2", 1, 2'b11, 16'h0F0F, 16'h00FF, 16'hF000);

    // backpressure: pointer is now 2; requester 0 wins alone
    io_bus.out_ready = 1'b0;
    set_lane(0, 2'b10, 16'h1234, 16'h00FF);
    io_bus.req = 4'b0001;
    tick();
    chk("bp_gnt", 32'(io_bus.gnt), 32'h1);
    io_bus.req = '0;
    tick();
    chk("bp_out", 32'(io_bus.out), 32'h12CB);
    held = io_bus.out;
    set_lane(2, 2'b01, 16'hF0F0, 16'hFF00);
    io_bus.req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_stable", 32'(io_bus.out), 32'(held));
      chk("bp_id",     32'(io_bus.out_id), 0);
      chk("bp_valid",  32'(io_bus.out_valid), 1);
      chk("bp_nognt",  32'(io_bus.gnt), 0);
    end
    io_bus.out_ready = 1'b1;
    tick();
    chk("bp_idle",  32'(io_bus.busy), 0);
    chk("bp_vdrop", 32'(io_bus.out_valid), 0);
    chk("bp_gnt0",  32'(io_bus.gnt), 0);
    tick();
    chk("bp_gnt2",  32'(io_bus.gnt), 32'h4);
    io_bus.req = '0;
    tick();
    chk("bp_out2",  32'(io_bus.out), 32'hF000);
    tick();

    // reset during EXEC
    set_lane(3, 2'b00, 16'h5A5A, 16'h0000);
    io_bus.req = 4'b1000;
    tick();
    chk("rm_gnt", 32'(io_bus.gnt), 32'h8);
    rst = 1'b1;
    tick();
    chk("rm_valid", 32'(io_bus.out_valid), 0);
    chk("rm_gnt0",  32'(io_bus.gnt), 0);
    chk("rm_busy",  32'(io_bus.busy), 0);
    chk("rm_out",   32'(io_bus.out), 0);
    rst = 1'b0;
    set_lane(1, 2'b01, 16'hFFFF, 16'h0F0F);
    set_lane(3, 2'b00, 16'h5A5A, 16'h0000);
    io_bus.req = 4'b1010;
    tick();
    chk("rm_gnt1", 32'(io_bus.gnt), 32'h2);
    io_bus.req = 4'b1000;
    tick();
    chk("rm_out1", 32'(io_bus.out), 32'h0F0F);
    tick();
    tick();
    chk("rm_gnt3", 32'(io_bus.gnt), 32'h8);
    io_bus.req = '0;
    tick();
    tick();

`ifdef BITWISE_ARB_GNTCNT_EN
    do_reset();
    chk("gc_rst", 32'(io_bus.gnt_cnt), 0);
    txn("gc_a", 0, 2'b00, 16'h0001, 16'h0002, 16'h0003);
    txn("gc_b", 1, 2'b01, 16'h00FF, 16'h0F0F, 16'h000F);
    txn("gc_c", 2, 2'b10, 16'hFFFF, 16'h0001, 16'hFFFE);
    chk("gc_three", 32'(io_bus.gnt_cnt), 3);
    force dut.r_gnt_cnt = 16'hFFFE;
    #1;
    release dut.r_gnt_cnt;
    txn("gc_d", 3, 2'b11, 16'h0000, 16'h0000, 16'hFFFF);
    chk("gc_max", 32'(io_bus.gnt_cnt), 32'hFFFF);
    txn("gc_e", 0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
    chk("gc_sat", 32'(io_bus.gnt_cnt), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bitwise_unit_arbiter.md
Name: bitwise_unit_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (OR/AND/XOR/NOR) among NREQ requesters.
- Round-robin arbitration, registered operand capture, registered result with valid/ready handshake.
- Sits between the register-file/control requesters and the ALU bitwise slice. Replaces per-requester copies of 16-bit gate arrays with one shared instance.

Parameters:
- WIDTH, 16, operand/result width in bits.
- NREQ, 4, number of requesters; supported range 2..4.
- IDW, 2, width of requester index; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  NREQ  per-requester request; bit i = requester i.
- op_bus  input  2*NREQ  opcode of requester i at [2i+1:2i]. 00=OR, 01=AND, 10=XOR, 11=NOR.
- x_bus  input  WIDTH*NREQ  operand x of requester i at [WIDTH*i +: WIDTH].
- y_bus  input  WIDTH*NREQ  operand y of requester i, same packing.
- gnt  output  NREQ  one-hot registered grant, high exactly one cycle per accepted request.
- out  output  WIDTH  result of the granted operation.
- out_id  output  IDW  index of the requester that owns out.
- out_valid  output  1  out/out_id valid.
- out_ready  input  1  consumer accepts result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, gnt=0, out=0, out_id=0, out_valid=0, busy=0, rr pointer=0, latched operands=0.
- Reset mid-operation: a pending result is discarded and no gnt is reissued. Requesters re-request.
- FSM states:
  - IDLE: at an edge with req!=0, select the winner, latch op/x/y of the winner, set gnt<=onehot(winner) and out_id<=winner, set pointer<=(winner+1) mod NREQ, go to EXEC. With req==0, remain in IDLE and keep gnt=0.
  - EXEC: gnt<=0. out<=f(op,x,y) from the latched operands. out_valid<=1. Go to HOLD.
  - HOLD: out, out_id and out_valid are held stable. At an edge with out_ready=1: out_valid<=0, go to IDLE. With out_ready=0, remain in HOLD indefinitely.
- Round-robin selection: the first set req bit at or after the pointer index, scanning upward and wrapping from NREQ-1 to 0.
- Requests are sampled only in IDLE. req seen in EXEC/HOLD is ignored, not queued.
- Requester contract: hold req, op, x and y stable until it sees its gnt bit. Deassert req in the gnt cycle or earlier. A req still high after gnt is treated as a new request.
- Latency: req sampled at edge N; gnt high during cycle N+1; out_valid high from cycle N+2.
  - Minimum 3 cycles per transaction when out_ready is tied high. The next grant is then visible in cycle N+4.
- Arithmetic: pure bitwise, per bit, no carries.
  - NOR = ~(x|y), truncated to WIDTH.
  - No flags.
- out is not cleared when out_valid falls. It holds its last value until the next EXEC.
- Unused req bits above NREQ do not exist. No X may propagate from unselected operand lanes.

Optional Feature:
- Macro: BITWISE_ARB_GNTCNT_EN.
- When the macro is defined:
  - Add output gnt_cnt [15:0], which increments by 1 on every cycle in which gnt!=0.
  - gnt_cnt saturates at 16'hFFFF and is cleared by rst.
- When the macro is not defined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Single request: rst pulse, then req=0001, op0=00, x0=16'h00F0, y0=16'h0F00, out_ready=1. Expect gnt=0001 one cycle, then out=16'h0FF0, out_id=0, out_valid=1 for one cycle.
- Round-robin fairness: req=1111 held high, each requester re-asserting after its own gnt. Expect grant order 0,1,2,3,0 and out_id matching each result.
- Opcode coverage: requester 2 with x=16'hAAAA, y=16'hFFFF. Expect OR=16'hFFFF, AND=16'hAAAA, XOR=16'h5555, NOR=16'h0000.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with req=0100 pending. Expect out and out_id stable, no gnt while in HOLD. After out_ready=1, expect IDLE then gnt=0100.
- Reset mid-op: rst asserted during EXEC. Expect out_valid=0, gnt=0, busy=0 next cycle, pointer=0. With req=1010, the next grant goes to requester 1.
- Grant counter, with the macro defined: 3 transactions give gnt_cnt=3. Force the counter near 16'hFFFF and check it saturates there.
